// File: rtl/credit_tx_if.sv
// Bus bundle between the upstream producer, the credit transmitter and the receiver.
// Carries the word handshake, credit returns, drain control and status.
// master = producer/controller side, slave = credit_tx side.
interface credit_tx_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 3
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  credit_return;
  logic                  drain_req;
  logic                  drained;
  logic [CNT_WIDTH-1:0]  credits;
  logic                  credit_err;

  modport master (
    output in_valid, in_data, credit_return, drain_req,
    input  in_ready, out_valid, out_data, drained, credits, credit_err
  );

  modport slave (
    input  in_valid, in_data, credit_return, drain_req,
    output in_ready, out_valid, out_data, drained, credits, credit_err
  );
endinterface

// File: rtl/credit_tx.sv
// Credit-based transmitter: launches accepted words toward a receiver FIFO, tracks free slots.
// Latency: accept to out_valid is 1 cycle (registered pulse).
// Backpressure: in_ready drops when credits hit zero, while draining, or on drain_req.
module credit_tx #(
  parameter int DATA_WIDTH  = 16,
  parameter int MAX_CREDITS = 4,
  parameter int CNT_WIDTH   = 3
) (
  input logic         clk,
  input logic         reset,
  credit_tx_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_CREDITS);
  localparam logic [CNT_WIDTH:0]   MAX_EXT = (CNT_WIDTH+1)'(MAX_CREDITS);

  state_t                state_q;
  logic [CNT_WIDTH-1:0]  credits_q;
  logic [CNT_WIDTH-1:0]  credits_d;
  logic                  err_q;
  logic                  err_d;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  drained_q;
  logic                  in_ready_w;
  logic                  accept_w;
  logic [CNT_WIDTH:0]    cnt_ext;
  logic [CNT_WIDTH:0]    cnt_next;

  // Ready depends only on registered state/credits plus drain_req, so a credit
  // returned this cycle cannot be spent until the next one.
  always_comb begin
    in_ready_w = (state_q == ST_RUN) && (credits_q != '0) && !bus.drain_req;
    accept_w   = bus.in_valid && in_ready_w;
  end

  // Up/down credit arithmetic one bit wider than the counter; saturates at the
  // receiver depth and flags a return that would push past it.
  always_comb begin
    cnt_ext  = {1'b0, credits_q};
    cnt_next = cnt_ext;
    err_d    = err_q;
    if (accept_w && !bus.credit_return) begin
      cnt_next = cnt_ext - 1'b1;
    end else if (!accept_w && bus.credit_return) begin
      if (cnt_ext >= MAX_EXT) begin
        cnt_next = MAX_EXT;
        err_d    = 1'b1;
      end else begin
        cnt_next = cnt_ext + 1'b1;
      end
    end
    credits_d = cnt_next[CNT_WIDTH-1:0];
  end

  // Control FSM plus all registered outputs: launch pulse, credit count, sticky error, drained level.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      credits_q   <= MAX_CNT;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      drained_q   <= 1'b0;
    end else begin
      out_valid_q <= accept_w;
      if (accept_w) begin
        out_data_q <= bus.in_data;
      end
      credits_q <= credits_d;
      err_q     <= err_d;
      case (state_q)
        ST_RUN: begin
          if (bus.drain_req) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // A return landing this cycle means a word is still being consumed.
          if ((credits_q == MAX_CNT) && !bus.credit_return) begin
            state_q   <= ST_DONE;
            drained_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!bus.drain_req) begin
            state_q   <= ST_RUN;
            drained_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_RUN;
          drained_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_w;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.credits    = credits_q;
  assign bus.credit_err = err_q;
  assign bus.drained    = drained_q;

endmodule

// File: tb/tb_credit_tx.sv
// Directed bench for credit_tx: burst, stall/return, simultaneous accept+return,
// overflow, drain handshake and mid-burst reset, with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_credit_tx;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  int   pulses;

  credit_tx_if #(.DATA_WIDTH(16), .CNT_WIDTH(3)) bus ();

  credit_tx #(
    .DATA_WIDTH (16),
    .MAX_CREDITS(4),
    .CNT_WIDTH  (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge and apply the inputs for this cycle.
  task automatic drive(input logic rst, input logic vld, input logic [15:0] dat,
                       input logic ret, input logic drn);
    @(posedge clk);
    #1;
    reset             = rst;
    bus.in_valid      = vld;
    bus.in_data       = dat;
    bus.credit_return = ret;
    bus.drain_req     = drn;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks          = 0;
    n_errors          = 0;
    pulses            = 0;
    reset             = 1'b1;
    bus.in_valid      = 1'b0;
    bus.in_data       = 16'h0000;
    bus.credit_return = 1'b0;
    bus.drain_req     = 1'b0;

    // Reset state
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    check("rst_credits",   32'(bus.credits),    32'd4);
    check("rst_out_valid", 32'(bus.out_valid),  32'd0);
    check("rst_out_data",  32'(bus.out_data),   32'd0);
    check("rst_drained",   32'(bus.drained),    32'd0);
    check("rst_err",       32'(bus.credit_err), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready),   32'd1);

    // Burst with no returns: producer holds each word until accepted (1..4 go, 5 stalls)
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 16'((i < 4) ? i + 1 : 5), 1'b0, 1'b0);
      @(negedge clk);
      check("burst_in_ready", 32'(bus.in_ready), (i < 4) ? 32'd1 : 32'd0);
      check("burst_credits",  32'(bus.credits),  (i < 4) ? 32'(4 - i) : 32'd0);
      check("burst_out_valid", 32'(bus.out_valid), (i >= 1 && i <= 4) ? 32'd1 : 32'd0);
      if (i >= 1 && i <= 4) check("burst_out_data", 32'(bus.out_data), 32'(i));
      if (bus.out_valid) pulses++;
    end
    check("burst_pulses", 32'(pulses), 32'd4);

    // One return while stalled at zero credits
    drive(1'b0, 1'b1, 16'h0005, 1'b1, 1'b0);
    @(negedge clk);
    check("stall_credits",  32'(bus.credits),  32'd0);
    check("stall_in_ready", 32'(bus.in_ready), 32'd0);
    drive(1'b0, 1'b1, 16'h0005, 1'b0, 1'b0);
    @(negedge clk);
    check("ret_credits",  32'(bus.credits),  32'd1);
    check("ret_in_ready", 32'(bus.in_ready), 32'd1);
    drive(1'b0, 1'b0, 16'h0006, 1'b0, 1'b0);
    @(negedge clk);
    check("ret_out_valid", 32'(bus.out_valid), 32'd1);
    check("ret_out_data",  32'(bus.out_data),  32'h0005);
    check("ret_credits0",  32'(bus.credits),   32'd0);

    // Bring credits to 2, then accept and return in the same cycle
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 16'h0006, 1'b1, 1'b0);
    @(negedge clk);
    check("simul_pre_credits", 32'(bus.credits), 32'd2);
    idle();
    @(negedge clk);
    check("simul_credits",   32'(bus.credits),   32'd2);
    check("simul_out_valid", 32'(bus.out_valid), 32'd1);
    check("simul_out_data",  32'(bus.out_data),  32'h0006);

    // Overflow: refill to 4, then one extra return
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    check("ovf_pre_credits", 32'(bus.credits),    32'd4);
    check("ovf_pre_err",     32'(bus.credit_err), 32'd0);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    check("ovf_credits", 32'(bus.credits),    32'd4);
    check("ovf_err",     32'(bus.credit_err), 32'd1);
    idle();
    @(negedge clk);
    check("ovf_err_sticky", 32'(bus.credit_err), 32'd1);
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    check("ovf_err_cleared",  32'(bus.credit_err), 32'd0);
    check("ovf_rst_credits",  32'(bus.credits),    32'd4);

    // Drain: 3 words out, then drain_req with a word still offered
    drive(1'b0, 1'b1, 16'h0011, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'h0012, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'h0013, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'h0014, 1'b0, 1'b1);
    @(negedge clk);
    check("drn_credits",  32'(bus.credits),  32'd1);
    check("drn_in_ready", 32'(bus.in_ready), 32'd0);
    drive(1'b0, 1'b1, 16'h0014, 1'b1, 1'b1);
    @(negedge clk);
    check("drn_no_accept", 32'(bus.out_valid), 32'd0);
    check("drn_in_ready2", 32'(bus.in_ready),  32'd0);
    drive(1'b0, 1'b1, 16'h0014, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 16'h0014, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 16'h0014, 1'b0, 1'b1);
    @(negedge clk);
    check("drn_full_credits", 32'(bus.credits),   32'd4);
    check("drn_not_yet",      32'(bus.drained),   32'd0);
    check("drn_out_valid",    32'(bus.out_valid), 32'd0);
    drive(1'b0, 1'b1, 16'h0014, 1'b0, 1'b1);
    @(negedge clk);
    check("drn_drained",  32'(bus.drained),  32'd1);
    check("drn_done_rdy", 32'(bus.in_ready), 32'd0);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    check("drn_drop_drained", 32'(bus.drained),  32'd1);
    check("drn_drop_rdy",     32'(bus.in_ready), 32'd0);
    idle();
    @(negedge clk);
    check("drn_run_drained", 32'(bus.drained),  32'd0);
    check("drn_run_rdy",     32'(bus.in_ready), 32'd1);

    // Reset on the cycle after an accept
    drive(1'b0, 1'b1, 16'h0021, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 16'h0022, 1'b0, 1'b0);
    @(negedge clk);
    check("mid_inflight", 32'(bus.out_valid), 32'd1);
    check("mid_inflight_data", 32'(bus.out_data), 32'h0021);
    drive(1'b0, 1'b1, 16'h0022, 1'b0, 1'b0);
    @(negedge clk);
    check("mid_out_valid", 32'(bus.out_valid),  32'd0);
    check("mid_credits",   32'(bus.credits),    32'd4);
    check("mid_drained",   32'(bus.drained),    32'd0);
    check("mid_err",       32'(bus.credit_err), 32'd0);
    idle();
    @(negedge clk);
    check("mid_resume_valid",   32'(bus.out_valid), 32'd1);
    check("mid_resume_data",    32'(bus.out_data),  32'h0022);
    check("mid_resume_credits", 32'(bus.credits),   32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/credit_tx.md
# credit_tx

Credit-based transmit end for PE output traffic (psum/ifmap forwarding) into the neighbouring receiver FIFO. Accepts words through a valid/ready handshake, launches each as a one-cycle registered pulse, and tracks downstream free slots with an up/down credit count. Each transmitted word consumes one credit; each `credit_return` pulse from the receiver restores one. The block also provides a drain sequence so the controller can confirm that every in-flight word has been consumed before a pass switch.

## Interface
- `DATA_WIDTH`, 16: width of the transferred word.
- `MAX_CREDITS`, 4: depth of the receiver FIFO; initial and maximum credit count; legal range 1..(2^CNT_WIDTH − 1).
- `CNT_WIDTH`, 3: width of the credit counter.

- `clk`  input  1: single clock; all state updates on the rising edge.
- `reset`  input  1: synchronous, active-high reset.
- `in_valid`  input  1: upstream word available.
- `in_data`  input  DATA_WIDTH: upstream word.
- `in_ready`  output  1: block can accept a word this cycle (combinational).
- `out_valid`  output  1: one-cycle pulse, word launched to receiver.
- `out_data`  output  DATA_WIDTH: launched word, valid only when `out_valid`=1.
- `credit_return`  input  1: one-cycle pulse, receiver freed one slot.
- `drain_req`  input  1: request to stop accepting and wait for all credits.
- `drained`  output  1: level, all credits home after a drain.
- `credits`  output  CNT_WIDTH: current credit count.
- `credit_err`  output  1: sticky flag, credit overflow observed.

## Operation
- Reset values: `credits`=MAX_CREDITS, state=RUN, `out_valid`=0, `out_data`=0, `drained`=0, `credit_err`=0.
- FSM states:
  - RUN: normal transfer. On `drain_req`=1, go to DRAIN. `drain_req` has priority over a transfer in the same cycle: no accept.
  - DRAIN: `in_ready`=0. When `credits`==MAX_CREDITS and no `credit_return` is pending in this cycle, go to DONE.
  - DONE: `drained`=1, `in_ready`=0. When `drain_req` falls to 0, go to RUN. `drained` deasserts on that same edge.
- `in_ready` = (state==RUN) && (`credits`≠0) && !`drain_req`.
- Accept: `in_valid` && `in_ready`. On that edge, `out_valid`←1 and `out_data`←`in_data`. Otherwise `out_valid`←0 and `out_data` holds its value.
- Credit update, evaluated from accept (a) and `credit_return` (r):
  - a=1, r=0: `credits`−1.
  - a=0, r=1: `credits`+1.
  - a=1, r=1: unchanged.
  - a=0, r=0: unchanged.
- Underflow cannot occur, because accept requires `credits`≠0.
- Overflow: if r=1, a=0, and `credits`==MAX_CREDITS, then `credits` saturates at MAX_CREDITS and `credit_err`←1. `credit_err` stays set until `reset`.
- Arithmetic is performed at CNT_WIDTH+1 bits internally. The result is never allowed to wrap.
- `credit_return` is honoured in every state, including DRAIN and DONE. A return arriving in DONE is an overflow and sets `credit_err`.
- Reset mid-operation: any in-flight `out_valid` is cancelled on the reset edge. Credits return to MAX_CREDITS. Returns pending in the receiver after reset are the receiver's concern; both ends are reset together.

## Timing
- Latency from accept to `out_valid`: 1 cycle (registered output).
- Throughput: 1 word/cycle while `credits`≠0. A stream stalls after MAX_CREDITS words if no credits return.
- A credit returned at edge N is usable for an accept in cycle N+1. It is not usable in the same cycle, because `in_ready` depends on the registered `credits`.
- `drained` rises 1 cycle after the edge on which `credits` reaches MAX_CREDITS while in DRAIN.
- No combinational path from `credit_return` to `in_ready`. The only combinational input to `in_ready` is `drain_req`.

## Test plan
- Reset then burst: hold `in_valid`=1 with data 0x0001..0x0006 and no returns.
  - Expect exactly 4 `out_valid` pulses carrying 0x0001..0x0004.
  - `credits` goes 4→0; `in_ready`=0 from cycle 5 on.
- Return while stalled: from `credits`=0, pulse `credit_return` once.
  - Expect `credits`=1 on the next edge, one accept of 0x0005 the cycle after, and `credits` back to 0.
- Simultaneous accept and return at `credits`=2: expect `credits` stays 2 and `out_valid`=1 with the accepted word.
- Overflow: with `credits`=4 and no accept, pulse `credit_return`.
  - Expect `credits` stays 4 and `credit_err`=1.
  - `credit_err` stays high until `reset`, then reads 0.
- Drain: send 3 words (`credits`=1), assert `drain_req` with `in_valid`=1.
  - Expect `in_ready`=0 and no further accepts.
  - Return 3 credits one per cycle; `drained`=1 one cycle after `credits`=4.
  - Drop `drain_req`; expect RUN and `in_ready`=1 on the next cycle.
- Reset mid-burst: assert `reset` on the cycle after an accept.
  - Expect `out_valid`=0, `credits`=4, `drained`=0, `credit_err`=0 after the reset edge.
  - Normal accepts resume after `reset` falls.
